// File: rtl/result_write_arbiter.sv
// Two-lane result writer: per-lane FIFOs drained by a round-robin scheduler into one registered RAM write port.
// Optional RESULT_ARB_FIXED_PRIO_EN: lane 0 always wins under contention (no round-robin pointer).
module result_write_arbiter #(
  parameter int DATA_W          = 19,
  parameter int ADDR_W          = 6,
  parameter int FIFO_DEPTH      = 4,
  parameter int EXPECTED_WRITES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [10:0]       write_count,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [10:0]      DONE_CNT = 11'(EXPECTED_WRITES);

  logic             restart;
  logic [ENT_W-1:0] mem0 [FIFO_DEPTH];
  logic [ENT_W-1:0] mem1 [FIFO_DEPTH];
  logic [PTR_W-1:0] wp0, rp0, wp1, rp1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             ne0, ne1, full0, full1;
  logic             push0, push1;
  logic             grant0, grant1;
  logic [ENT_W-1:0] head0, head1;

  assign restart = reset | clear;

  // Handshake: a lane transfers on a rising edge where valid && ready; ready comes
  // only from registered state (FIFO full, done), and the producer holds
  // addr/data stable while valid && !ready.
  assign full0     = (cnt0 == FULL_CNT);
  assign full1     = (cnt1 == FULL_CNT);
  assign ne0       = (cnt0 != '0);
  assign ne1       = (cnt1 != '0);
  assign in0_ready = !full0 && !done;
  assign in1_ready = !full1 && !done;
  assign push0     = in0_valid && in0_ready;
  assign push1     = in1_valid && in1_ready;
  assign head0     = mem0[rp0];
  assign head1     = mem1[rp1];
  assign busy      = ne0 | ne1 | wr_en;

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= {in0_addr, in0_data};
    if (push1) mem1[wp1] <= {in1_addr, in1_data};
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
    end else begin
      if (push0)  wp0 <= wp0 + PTR_ONE;
      if (grant0) rp0 <= rp0 + PTR_ONE;
      case ({push0, grant0})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   cnt0 <= cnt0 - CNT_ONE;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push1)  wp1 <= wp1 + PTR_ONE;
      if (grant1) rp1 <= rp1 + PTR_ONE;
      case ({push1, grant1})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   cnt1 <= cnt1 - CNT_ONE;
        default: cnt1 <= cnt1;
      endcase
    end
  end

`ifdef RESULT_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!done) begin
      grant0 = ne0;
      grant1 = ne1 && !ne0;
    end
  end
`else
  logic pref1;  // 1: lane 1 is preferred on the next contended cycle

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!done) begin
      grant0 = ne0 && (!ne1 || !pref1);
      grant1 = ne1 && !grant0;
    end
  end

  always_ff @(posedge clk) begin
    if (restart)     pref1 <= 1'b0;
    else if (grant0) pref1 <= 1'b1;
    else if (grant1) pref1 <= 1'b0;
  end
`endif

  // Once done is set no further grants occur, so the count cannot pass the target.
  always_ff @(posedge clk) begin
    if (restart) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      write_count <= '0;
      done        <= 1'b0;
    end else begin
      wr_en <= grant0 | grant1;
      if (grant0) begin
        wr_addr <= head0[ENT_W-1:DATA_W];
        wr_data <= head0[DATA_W-1:0];
      end else if (grant1) begin
        wr_addr <= head1[ENT_W-1:DATA_W];
        wr_data <= head1[DATA_W-1:0];
      end
      if (grant0 | grant1) begin
        if (write_count != DONE_CNT) write_count <= write_count + 11'd1;
        if ((write_count + 11'd1) == DONE_CNT) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_write_arbiter.sv
// Bench for result_write_arbiter: a table of per-cycle vectors, then directed
// sequences for flooding, mid-run reset, completion and clear.
module tb_result_write_arbiter;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset, clear;
  logic              in0_valid, in0_ready, in1_valid, in1_ready;
  logic [ADDR_W-1:0] in0_addr, in1_addr;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [10:0]       write_count;

  result_write_arbiter dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .write_count(write_count), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int n_writes = 0;
  logic sb_on = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] src0[$];
  logic [ADDR_W-1:0] src1[$];

  typedef struct {
    logic        rst;
    logic        v0;
    logic [5:0]  a0;
    logic        v1;
    logic [5:0]  a1;
    logic        e_en;
    logic [5:0]  e_addr;
    logic        e_r0;
    logic        e_r1;
    logic [10:0] e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  // Data tied to the address so every write is self-describing; addr 5 gives -3.
  function automatic logic [DATA_W-1:0] data_of(logic [ADDR_W-1:0] a);
    int v;
    v = int'(a) * 7 - 38;
    return DATA_W'(v);
  endfunction

  function automatic vec_t mk(logic rst, logic v0, int a0, logic v1, int a1,
                              logic e_en, int e_addr, logic e_r0, logic e_r1,
                              int e_cnt, logic e_busy);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = 6'(a0); v.v1 = v1; v.a1 = 6'(a1);
    v.e_en = e_en; v.e_addr = 6'(e_addr); v.e_r0 = e_r0; v.e_r1 = e_r1;
    v.e_cnt = 11'(e_cnt); v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, then sample; the scoreboard consumes every observed write.
  task automatic tick();
    logic [ADDR_W-1:0] e;
    @(posedge clk);
    #1;
    if (wr_en) begin
      n_writes++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_extra_write: got write to addr %0d, expected no write", wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", 32'(wr_addr), 32'(e));
          check("sb_data", 32'(wr_data), 32'(data_of(e)));
        end
      end
    end
  endtask

  // driver: offer each lane's queue head, drop it once accepted
  task automatic prod_cycle();
    logic acc0, acc1;
    in0_valid = (src0.size() > 0);
    in0_addr  = in0_valid ? src0[0] : '0;
    in0_data  = data_of(in0_addr);
    in1_valid = (src1.size() > 0);
    in1_addr  = in1_valid ? src1[0] : '0;
    in1_data  = data_of(in1_addr);
    acc0 = in0_valid && in0_ready;
    acc1 = in1_valid && in1_ready;
    tick();
    if (acc0) void'(src0.pop_front());
    if (acc1) void'(src1.pop_front());
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
    in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    src0.delete();
    src1.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_lanes(string name, int budget);
    int c;
    c = 0;
    while ((src0.size() > 0 || src1.size() > 0 || busy) && c < budget) begin
      prod_cycle();
      c++;
    end
    idle_inputs();
    check({name, "_timeout"}, 32'(c < budget), 32'd1);
  endtask

  task automatic check_cleared(string name);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_count"}, 32'(write_count), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_ready0"}, 32'(in0_ready), 32'd1);
    check({name, "_ready1"}, 32'(in1_ready), 32'd1);
  endtask

  initial begin
    logic got_done;
    reset = 1'b1;
    clear = 1'b0;
    idle_inputs();
    repeat (2) tick();
    check_cleared("reset");

    // rst v0 a0 v1 a1 | en addr r0 r1 cnt busy
    // single lane-0 push: written in the cycle after the second edge
    tbl.push_back(mk(0, 1, 5, 0, 0,    0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 5, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 5, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0, 1, 1, 0, 0));
    // both lanes push every cycle; producers hold while ready is low
    tbl.push_back(mk(0, 1, 0, 1, 32,   0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 33,   1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2, 1, 34,   1, 32, 1, 1, 2, 1));
    tbl.push_back(mk(0, 1, 3, 1, 35,   1, 1, 1, 1, 3, 1));
    tbl.push_back(mk(0, 1, 4, 1, 36,   1, 33, 1, 1, 4, 1));
    tbl.push_back(mk(0, 1, 5, 1, 37,   1, 2, 1, 0, 5, 1));
    tbl.push_back(mk(0, 1, 6, 1, 38,   1, 34, 0, 1, 6, 1));
    tbl.push_back(mk(0, 1, 7, 1, 38,   1, 3, 1, 0, 7, 1));
    tbl.push_back(mk(0, 1, 7, 1, 39,   1, 35, 0, 1, 8, 1));
    tbl.push_back(mk(0, 0, 0, 1, 39,   1, 4, 1, 0, 9, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 36, 1, 1, 10, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 5, 1, 1, 11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 37, 1, 1, 12, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 6, 1, 1, 13, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 38, 1, 1, 14, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 7, 1, 1, 15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1, 39, 1, 1, 16, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0, 39, 1, 1, 16, 0));

    reset = 1'b0;
    foreach (tbl[i]) begin
      reset     = tbl[i].rst;
      in0_valid = tbl[i].v0;
      in0_addr  = tbl[i].a0;
      in0_data  = data_of(tbl[i].a0);
      in1_valid = tbl[i].v1;
      in1_addr  = tbl[i].a1;
      in1_data  = data_of(tbl[i].a1);
      tick();
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].e_en));
      check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_en)
        check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(data_of(tbl[i].e_addr)));
      check($sformatf("v%0d_ready0", i), 32'(in0_ready), 32'(tbl[i].e_r0));
      check($sformatf("v%0d_ready1", i), 32'(in1_ready), 32'(tbl[i].e_r1));
      check($sformatf("v%0d_count", i), 32'(write_count), 32'(tbl[i].e_cnt));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("v%0d_done", i), 32'(done), 32'd0);
    end
    reset = 1'b0;
    idle_inputs();

    // both lanes flood: lane 1 is served every other write unless fixed priority
    reset_dut();
    sb_on = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      src0.push_back(6'(i));
      src1.push_back(6'(32 + i));
    end
`ifdef RESULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 10; i++) exp_q.push_back(6'(i));
    for (int i = 0; i < 10; i++) exp_q.push_back(6'(32 + i));
`else
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(6'(i));
      exp_q.push_back(6'(32 + i));
    end
`endif
    run_lanes("flood", 200);
    check("flood_leftover", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // reset while lane 0 holds three queued entries
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      src0.push_back(6'(i));
      src1.push_back(6'(32 + i));
    end
    repeat (5) prod_cycle();
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_dut();
    check_cleared("midrst");
    n_writes = 0;
    repeat (8) tick();
    check("midrst_no_writes", 32'(n_writes), 32'd0);

    // 64 writes complete the product; the 65th entry is never written
    reset_dut();
    sb_on = 1'b1;
    exp_q.delete();
    n_writes = 0;
    for (int i = 0; i < 32; i++) begin
      src0.push_back(6'(i));
      src1.push_back(6'(32 + i));
      exp_q.push_back(6'(i));
      exp_q.push_back(6'(32 + i));
    end
    src0.push_back(6'(17));
    got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      prod_cycle();
      check("cnt_track", 32'(write_count), 32'(n_writes));
      check("done_track", 32'(done), 32'(n_writes == 64));
      got_done = done;
    end
    check("done_timeout", 32'(got_done), 32'd1);
    repeat (10) prod_cycle();
    check("done_count", 32'(write_count), 32'd64);
    check("done_sticky", 32'(done), 32'd1);
    check("done_ready0", 32'(in0_ready), 32'd0);
    check("done_ready1", 32'(in1_ready), 32'd0);
    check("done_writes", 32'(n_writes), 32'd64);
    check("done_leftover", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // clear restarts the product; a fresh push lands two edges later
    idle_inputs();
    src0.delete();
    src1.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_cleared("clear");
    in0_valid = 1'b1;
    in0_addr  = 6'd9;
    in0_data  = data_of(6'd9);
    tick();
    idle_inputs();
    check("clr_push_early", 32'(wr_en), 32'd0);
    tick();
    check("clr_push_wr_en", 32'(wr_en), 32'd1);
    check("clr_push_addr", 32'(wr_addr), 32'd9);
    check("clr_push_data", 32'(wr_data), 32'(data_of(6'd9)));
    check("clr_push_count", 32'(write_count), 32'd1);
    tick();
    check("clr_push_after", 32'(wr_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
